ps2_frame_receiver: RTL and testbench
=====================================

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 Parameter FILTER_DEPTH, default 8: number of consecutive equal samples needed before a filtered PS/2 line changes level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: Clock cycles allowed between PS/2 clock falling edges inside a frame (2 ms at 25 MHz).
REQ-003 Clock  input  1  system clock; all logic is on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 PS2_CLK  input  1  raw PS/2 clock from the pad, asynchronous.
REQ-006 PS2_DATA  input  1  raw PS/2 data from the pad, asynchronous.
REQ-007 oScanCode  output  8  last accepted byte, LSB first as received.
REQ-008 oValid  output  1  one-cycle strobe; oScanCode and the flags are valid only in this cycle.
REQ-009 oBreak  output  1  the byte was preceded by 8'hF0.
REQ-010 oExtended  output  1  the byte was preceded by 8'hE0.
REQ-011 oParityError  output  1  one-cycle strobe when a frame fails the odd-parity check.
REQ-012 oFrameError  output  1  one-cycle strobe on a bad start bit, a bad stop bit or a timeout.

Function
REQ-013 Each raw line passes a 2-flop synchronizer and then a FILTER_DEPTH shift filter; the filtered output changes only when all samples agree.
REQ-014 A sample event is a 1->0 transition of the filtered clock; the data bit is taken from filtered data in that same cycle.
REQ-015 FSM states are IDLE, DATA, PARITY and STOP.
REQ-016 In IDLE, a sample event with data 0 goes to DATA with bit count 0; data 1 pulses oFrameError and stays in IDLE.
REQ-017 In DATA, each sample event shifts the bit into bit 7 of the shift register (right shift); after the 8th bit the FSM goes to PARITY.
REQ-018 In PARITY, the bit is stored; the FSM goes to STOP.
REQ-019 In STOP, data 1 with odd parity over data+parity bits is accepted; data 1 with wrong parity pulses oParityError; data 0 pulses oFrameError; all three cases return to IDLE.
REQ-020 Acceptance latency: oValid asserts exactly 1 cycle after the stop-bit sample event.
REQ-021 A timeout counter clears on every sample event. If it reaches TIMEOUT_CYCLES outside IDLE, the FSM returns to IDLE, pulses oFrameError and clears the bit count. No timeout is checked in IDLE.
REQ-022 There is no backpressure: a new byte overwrites oScanCode; bytes are never queued.
REQ-023 Error strobes and oValid are mutually exclusive in any cycle.

Reset
REQ-024 While Reset is 0: FSM in IDLE, counters 0, filters and synchronizers at 1 (idle bus level), oScanCode 8'h00, all strobes and flags 0, pending prefixes cleared.
REQ-025 Reset asserted mid-frame discards the partial frame; after release, the first sample event is treated as a start bit.

Configuration
REQ-026 Macro PS2_PREFIX_DECODE_EN defined: 8'hF0 sets pending-break and 8'hE0 sets pending-extended, with no oValid. The next other byte is output with oBreak/oExtended from the pending flags, which then clear. A parity, frame or timeout error also clears the pending flags.
REQ-027 Macro undefined: every accepted byte, prefixes included, strobes oValid; oBreak and oExtended are tied to 0.

Structure
REQ-028 Shared package ps2_pkg holds the FSM state encoding, PS2_BREAK_CODE = 8'hF0 and PS2_EXT_CODE = 8'hE0.
REQ-029 Sub-module ps2_input_filter (synchronizer + shift filter, FILTER_DEPTH parameter) is instantiated twice, once per line.

Verification
REQ-030 Send frame 8'h1C, correct odd parity (parity bit 0), stop 1 -> one oValid, oScanCode=8'h1C, oBreak=0, oExtended=0, 1 cycle after stop edge.
REQ-031 With macro defined, send F0 then 1C -> single oValid with oScanCode=8'h1C, oBreak=1; without macro -> two oValid (8'hF0, 8'h1C), oBreak=0.
REQ-032 With macro defined, send E0, F0, 75 -> single oValid, oScanCode=8'h75, oExtended=1, oBreak=1; the following 8'h75 gives oBreak=0, oExtended=0.
REQ-033 Send 8'h1C with parity bit 1 -> oParityError pulse, no oValid; then a clean 8'h29 -> oValid with 8'h29.
REQ-034 Stop clocking after 4 data bits for TIMEOUT_CYCLES+10 cycles -> one oFrameError pulse, FSM in IDLE; next clean frame 8'h5A is received correctly.
REQ-035 Glitch: PS2_CLK low pulse shorter than FILTER_DEPTH cycles in IDLE -> no sample event, no strobes; assert Reset mid-frame -> all outputs 0 and the next frame is decoded correctly.

Source files
------------

// File: rtl/ps2_frame_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ps2_pkg                                                      |
// | Description : Shared definitions for the PS/2 frame receiver: receive FSM  |
// |               state encoding, prefix byte codes and the odd-parity helper. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ps2_pkg;

  // Receive FSM state encoding
  typedef logic [1:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  // Scan-code prefix bytes
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  // PS/2 frames use odd parity: data bits plus the parity bit hold an odd
  // number of ones.
  function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : ps2_frame_receiver_if                                        |
// | Description : Decoded-byte output bundle of the PS/2 frame receiver.       |
// |   oScanCode    [7:0] last accepted byte                                    |
// |   oValid             one-cycle strobe, oScanCode/flags valid this cycle    |
// |   oBreak             byte was preceded by F0 (prefix decode builds only)   |
// |   oExtended          byte was preceded by E0 (prefix decode builds only)   |
// |   oParityError       one-cycle strobe on odd-parity failure                |
// |   oFrameError        one-cycle strobe on bad start/stop bit or timeout     |
// |   modport master : receiver side (drives)                                  |
// |   modport slave  : consumer side (observes)                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface ps2_frame_receiver_if;
  logic [7:0] oScanCode;
  logic       oValid;
  logic       oBreak;
  logic       oExtended;
  logic       oParityError;
  logic       oFrameError;

  modport master (
    output oScanCode,
    output oValid,
    output oBreak,
    output oExtended,
    output oParityError,
    output oFrameError
  );

  modport slave (
    input oScanCode,
    input oValid,
    input oBreak,
    input oExtended,
    input oParityError,
    input oFrameError
  );
endinterface
`default_nettype wire

// File: rtl/ps2_frame_receiver_input_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_input_filter                                             |
// | Description : Two-flop synchronizer followed by a FILTER_DEPTH-sample      |
// |               agreement filter for one raw PS/2 pad line.                  |
// |   Clock    in   system clock                                               |
// |   Reset    in   asynchronous active-low reset                              |
// |   rawIn    in   asynchronous pad line                                      |
// |   filtOut  out  filtered level (idle-high after reset)                     |
// | Parameters  : FILTER_DEPTH - consecutive equal samples to change level     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ps2_input_filter #(
  parameter int FILTER_DEPTH = 8
) (
  input  wire logic Clock,
  input  wire logic Reset,
  input  wire logic rawIn,
  output logic      filtOut
);

  logic                    r_sync1;
  logic                    r_sync2;
  logic [FILTER_DEPTH-1:0] r_shift;
  logic [FILTER_DEPTH-1:0] w_nextShift;
  logic                    r_out;

  // The agreement test looks at the window including the sample being
  // shifted in this cycle, so the output moves on the same edge that the
  // window becomes uniform.
  generate
    if (FILTER_DEPTH > 1) begin : g_deep
      assign w_nextShift = {r_shift[FILTER_DEPTH-2:0], r_sync2};
    end else begin : g_single
      assign w_nextShift = r_sync2;
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_shift <= '1;
      r_out   <= 1'b1;
    end else begin
      r_sync1 <= rawIn;
      r_sync2 <= r_sync1;
      r_shift <= w_nextShift;
      if (&w_nextShift) begin
        r_out <= 1'b1;
      end else if (~|w_nextShift) begin
        r_out <= 1'b0;
      end
    end
  end

  assign filtOut = r_out;

endmodule
`default_nettype wire

// File: rtl/ps2_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_frame_receiver                                           |
// | Description : PS/2 device-to-host frame receiver. Filters the raw clock    |
// |               and data lines, samples data on filtered clock falling       |
// |               edges, checks start/parity/stop and a per-bit timeout, and   |
// |               presents each accepted byte as a one-cycle strobe.           |
// |   Clock     in   system clock (rising edge)                                |
// |   Reset     in   asynchronous active-low reset                             |
// |   PS2_CLK   in   raw PS/2 clock pad                                        |
// |   PS2_DATA  in   raw PS/2 data pad                                         |
// |   bus       ps2_frame_receiver_if.master  decoded byte and strobes         |
// | Parameters  : FILTER_DEPTH   - input filter agreement depth                |
// |               TIMEOUT_CYCLES - max cycles between falling edges in a frame |
// | Macro       : PS2_PREFIX_DECODE_EN - fold F0/E0 prefixes into oBreak and   |
// |               oExtended instead of emitting them as bytes                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_DEPTH   = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic               Clock,
  input  wire logic               Reset,
  input  wire logic               PS2_CLK,
  input  wire logic               PS2_DATA,
  ps2_frame_receiver_if.master    bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Filtered lines and edge detection
  logic w_clkF;
  logic w_dataF;
  logic r_clkPrev;
  logic w_sample;

  // FSM and datapath
  ps2_state_t r_state;
  ps2_state_t w_nextState;
  logic [2:0]    r_bitCount;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_timer;
  logic          w_timeout;

  // Per-cycle decisions from the output decoder
  logic w_shiftEn;
  logic w_parityLoad;
  logic w_accept;
  logic w_parErr;
  logic w_frmErr;
  logic w_emit;

  // Registered outputs
  logic [7:0] r_scanCode;
  logic       r_valid;
  logic       r_parErr;
  logic       r_frmErr;

  ps2_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_clkFilter (
    .Clock   (Clock),
    .Reset   (Reset),
    .rawIn   (PS2_CLK),
    .filtOut (w_clkF)
  );

  ps2_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_dataFilter (
    .Clock   (Clock),
    .Reset   (Reset),
    .rawIn   (PS2_DATA),
    .filtOut (w_dataF)
  );

  assign w_sample = r_clkPrev & ~w_clkF;

  // A falling edge in the same cycle restarts the timer, so it takes priority.
  assign w_timeout = (r_state != ST_IDLE) && !w_sample &&
                     (r_timer == TW'(TIMEOUT_CYCLES));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_nextState = r_state;
    if (w_timeout) begin
      w_nextState = ST_IDLE;
    end else if (w_sample) begin
      case (r_state)
        ST_IDLE:   if (!w_dataF) w_nextState = ST_DATA;
        ST_DATA:   if (r_bitCount == 3'd7) w_nextState = ST_PARITY;
        ST_PARITY: w_nextState = ST_STOP;
        ST_STOP:   w_nextState = ST_IDLE;
        default:   w_nextState = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- output decode
  always_comb begin
    w_shiftEn    = 1'b0;
    w_parityLoad = 1'b0;
    w_accept     = 1'b0;
    w_parErr     = 1'b0;
    w_frmErr     = w_timeout;
    if (w_sample) begin
      case (r_state)
        ST_IDLE:   w_frmErr = w_dataF;
        ST_DATA:   w_shiftEn = 1'b1;
        ST_PARITY: w_parityLoad = 1'b1;
        ST_STOP: begin
          if (!w_dataF) begin
            w_frmErr = 1'b1;
          end else if (oddParityOk(r_shift, r_parity)) begin
            w_accept = 1'b1;
          end else begin
            w_parErr = 1'b1;
          end
        end
        default: w_frmErr = 1'b0;
      endcase
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic r_pendBreak;
  logic r_pendExt;
  logic r_break;
  logic r_ext;
  logic w_isBrk;
  logic w_isExt;

  assign w_isBrk = (r_shift == PS2_BREAK_CODE);
  assign w_isExt = (r_shift == PS2_EXT_CODE);
  // Prefix bytes are absorbed into the pending flags, never emitted.
  assign w_emit  = w_accept && !w_isBrk && !w_isExt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pendBreak <= 1'b0;
      r_pendExt   <= 1'b0;
      r_break     <= 1'b0;
      r_ext       <= 1'b0;
    end else begin
      r_break <= w_emit & r_pendBreak;
      r_ext   <= w_emit & r_pendExt;
      if (w_parErr || w_frmErr) begin
        r_pendBreak <= 1'b0;
        r_pendExt   <= 1'b0;
      end else if (w_accept) begin
        if (w_isBrk) begin
          r_pendBreak <= 1'b1;
        end else if (w_isExt) begin
          r_pendExt <= 1'b1;
        end else begin
          r_pendBreak <= 1'b0;
          r_pendExt   <= 1'b0;
        end
      end
    end
  end

  assign bus.oBreak    = r_break;
  assign bus.oExtended = r_ext;
`else
  assign w_emit        = w_accept;
  assign bus.oBreak    = 1'b0;
  assign bus.oExtended = 1'b0;
`endif

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_clkPrev  <= 1'b1;
      r_bitCount <= 3'd0;
      r_shift    <= 8'h00;
      r_parity   <= 1'b0;
      r_timer    <= '0;
      r_scanCode <= 8'h00;
      r_valid    <= 1'b0;
      r_parErr   <= 1'b0;
      r_frmErr   <= 1'b0;
    end else begin
      r_clkPrev <= w_clkF;

      if (w_sample || w_timeout || (r_state == ST_IDLE)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      if (w_timeout || (w_sample && (r_state == ST_IDLE))) begin
        r_bitCount <= 3'd0;
      end else if (w_shiftEn) begin
        r_bitCount <= r_bitCount + 3'd1;
      end

      // LSB arrives first, so shifting right leaves bit 0 in place at the end.
      if (w_shiftEn) begin
        r_shift <= {w_dataF, r_shift[7:1]};
      end
      if (w_parityLoad) begin
        r_parity <= w_dataF;
      end

      r_valid  <= w_emit;
      r_parErr <= w_parErr;
      r_frmErr <= w_frmErr;
      if (w_emit) begin
        r_scanCode <= r_shift;
      end
    end
  end

  assign bus.oScanCode    = r_scanCode;
  assign bus.oValid       = r_valid;
  assign bus.oParityError = r_parErr;
  assign bus.oFrameError  = r_frmErr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_frame_receiver                                        |
// | Description : Self-checking bench for ps2_frame_receiver. Frames are       |
// |               bit-banged onto the pad lines; expected strobes are queued   |
// |               at the stop-bit falling edge and matched by a monitor.       |
// | Macro       : PS2_PREFIX_DECODE_EN selects prefix-folding expectations     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ps2_frame_receiver;
  import ps2_pkg::*;

  localparam int FD   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic Clock   = 1'b0;
  logic Reset   = 1'b0;
  logic ps2Clk  = 1'b1;
  logic ps2Data = 1'b1;
  int   cyc     = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  ps2_frame_receiver_if bus();

  ps2_frame_receiver #(.FILTER_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .PS2_CLK  (ps2Clk),
    .PS2_DATA (ps2Data),
    .bus      (bus)
  );

  // kind: 0 = valid byte, 1 = parity error, 2 = frame error; cyc < 0 = any time
  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    int         cyc;
  } ev_t;

  ev_t  sb[$];
  int   nChecks  = 0;
  int   nPass    = 0;
  int   nFail    = 0;
  int   nStrobes = 0;
  logic mPendBrk = 1'b0;
  logic mPendExt = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set while clock is high, then a full low/high period.
  // If doPush, the expected strobe is queued at the falling edge, timed at
  // sync (2) + filter window + edge register latency.
  task automatic clkBit(input logic b, input bit doPush, input ev_t e);
    @(negedge Clock);
    ps2Data = b;
    repeat (HALF) @(negedge Clock);
    if (doPush) begin
      e.cyc = cyc + FD + 3;
      sb.push_back(e);
    end
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge Clock);
    ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic parFlip, input logic stopBit);
    ev_t  e;
    bit   doPush;
    logic p;
    e.kind = 0; e.code = b; e.brk = 1'b0; e.ext = 1'b0; e.cyc = -1;
    p = (~^b) ^ parFlip;
    clkBit(1'b0, 0, e);
    for (int i = 0; i < 8; i++) clkBit(b[i], 0, e);
    clkBit(p, 0, e);
    doPush = 1;
    if (!stopBit) begin
      e.kind = 2; mPendBrk = 1'b0; mPendExt = 1'b0;
    end else if (parFlip) begin
      e.kind = 1; mPendBrk = 1'b0; mPendExt = 1'b0;
    end else begin
      e.kind = 0;
`ifdef PS2_PREFIX_DECODE_EN
      if (b == PS2_BREAK_CODE) begin
        mPendBrk = 1'b1; doPush = 0;
      end else if (b == PS2_EXT_CODE) begin
        mPendExt = 1'b1; doPush = 0;
      end else begin
        e.brk = mPendBrk; e.ext = mPendExt;
        mPendBrk = 1'b0; mPendExt = 1'b0;
      end
`endif
    end
    clkBit(stopBit, doPush, e);
    @(negedge Clock);
    ps2Data = 1'b1;
    repeat (HALF) @(negedge Clock);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge Clock);
    check(tag, sb.size(), 0);
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_scancode"}, bus.oScanCode, 8'h00);
    check({tag, "_valid"},    bus.oValid, 0);
    check({tag, "_break"},    bus.oBreak, 0);
    check({tag, "_ext"},      bus.oExtended, 0);
    check({tag, "_parerr"},   bus.oParityError, 0);
    check({tag, "_frmerr"},   bus.oFrameError, 0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge Clock) begin : mon
    int  n;
    int  k;
    ev_t e;
    if (Reset) begin
      n = int'(bus.oValid) + int'(bus.oParityError) + int'(bus.oFrameError);
      if (n != 0) begin
        nStrobes++;
        check("strobe_exclusive", n, 1);
        k = bus.oValid ? 0 : (bus.oParityError ? 1 : 2);
        if (sb.size() == 0) begin
          check("unexpected_strobe_kind", k, 32'hFF);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", k, e.kind);
          if (e.kind == 0) begin
            check("scancode", bus.oScanCode, e.code);
            check("break_flag", bus.oBreak, e.brk);
            check("ext_flag", bus.oExtended, e.ext);
          end
          if (e.cyc >= 0) check("strobe_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    ev_t e;
    int  s;
    e.kind = 2; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0; e.cyc = -1;

    // Reset state
    repeat (5) @(negedge Clock);
    checkOutputsZero("reset");
    Reset = 1'b1;
    repeat (30) @(negedge Clock);

    // Basic frame
    sendFrame(8'h1C, 1'b0, 1'b1);
    drain("drain_1c", 300);

    // Break prefix
    sendFrame(8'hF0, 1'b0, 1'b1);
    sendFrame(8'h1C, 1'b0, 1'b1);
    drain("drain_f0_1c", 300);

    // Extended + break prefixes, then a plain repeat
    sendFrame(8'hE0, 1'b0, 1'b1);
    sendFrame(8'hF0, 1'b0, 1'b1);
    sendFrame(8'h75, 1'b0, 1'b1);
    sendFrame(8'h75, 1'b0, 1'b1);
    drain("drain_e0_f0_75", 300);

    // Parity error then clean frame
    sendFrame(8'h1C, 1'b1, 1'b1);
    sendFrame(8'h29, 1'b0, 1'b1);
    drain("drain_parity", 300);

    // Bad stop bit, and a pending prefix discarded by it
    sendFrame(8'hF0, 1'b0, 1'b1);
    sendFrame(8'h1C, 1'b0, 1'b0);
    sendFrame(8'h6B, 1'b0, 1'b1);
    drain("drain_badstop", 300);

    // Bad start bit
    e.kind = 2; e.cyc = -1;
    clkBit(1'b1, 1, e);
    mPendBrk = 1'b0; mPendExt = 1'b0;
    repeat (HALF) @(negedge Clock);
    drain("drain_badstart", 300);

    // Timeout after 4 data bits
    e.kind = 2; e.cyc = -1;
    sb.push_back(e);
    mPendBrk = 1'b0; mPendExt = 1'b0;
    clkBit(1'b0, 0, e);
    clkBit(1'b0, 0, e);
    clkBit(1'b1, 0, e);
    clkBit(1'b0, 0, e);
    clkBit(1'b1, 0, e);
    ps2Data = 1'b1;
    repeat (TO + 10) @(negedge Clock);
    drain("drain_timeout", 300);
    sendFrame(8'h5A, 1'b0, 1'b1);
    drain("drain_5a", 300);

    // Clock glitch shorter than the filter window
    s = nStrobes;
    @(negedge Clock);
    ps2Data = 1'b1;
    ps2Clk  = 1'b0;
    repeat (FD - 3) @(negedge Clock);
    ps2Clk = 1'b1;
    repeat (60) @(negedge Clock);
    check("glitch_no_strobe", nStrobes, s);

    // Reset mid-frame
    clkBit(1'b0, 0, e);
    clkBit(1'b1, 0, e);
    clkBit(1'b1, 0, e);
    clkBit(1'b0, 0, e);
    Reset = 1'b0;
    mPendBrk = 1'b0; mPendExt = 1'b0;
    #1;
    checkOutputsZero("midreset");
    repeat (3) @(negedge Clock);
    ps2Data = 1'b1;
    Reset   = 1'b1;
    repeat (30) @(negedge Clock);
    sendFrame(8'h33, 1'b0, 1'b1);
    drain("drain_after_reset", 300);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
